// File: rtl/float_discriminant_arbiter_pkg.sv
// Shared types and the round-robin grant helper for the discriminant arbiter.
// The operand width and the default requester count are fixed here.
package float_discriminant_arbiter_pkg;

  localparam int FLEN      = 64;
  localparam int MAX_REQ   = 8;
  localparam int N_REQ_DEF = 4;
  localparam int TAG_W     = $clog2(N_REQ_DEF);

  typedef logic [TAG_W-1:0] tag_t;

  // Searches ptr, ptr+1, ... modulo n and returns a one-hot grant for the first set request.
  function automatic logic [MAX_REQ-1:0] rr_grant(input logic [MAX_REQ-1:0] req,
                                                  input logic [2:0]         ptr,
                                                  input int                 n);
    logic [MAX_REQ-1:0] g;
    logic               found;
    int                 idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && req[idx[2:0]]) begin
        g[idx[2:0]] = 1'b1;
        found       = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/float_discriminant_arbiter_disc_tag_fifo.sv
// In-order FIFO of requester IDs for issued operations; the head is read combinationally
// so a result can be steered in the cycle it arrives.
module disc_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop frees the slot being written, so a push into a full FIFO is safe alongside it.
  assign push_ok = push & (~full | pop_ok);
  assign count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  assign dout    = mem[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/float_discriminant_arbiter.sv
// Round-robin arbiter sharing one pipelined discriminant unit between N_REQ requesters,
// with an in-order tag FIFO that steers each result back to its issuer.
module float_discriminant_arbiter
  import float_discriminant_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 16,
  parameter int TAG_W     = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_vld,
  input  logic [N_REQ*FLEN-1:0] req_a,
  input  logic [N_REQ*FLEN-1:0] req_b,
  input  logic [N_REQ*FLEN-1:0] req_c,
  output logic [N_REQ-1:0]      req_rdy,
  output logic                  disc_arg_vld,
  output logic [FLEN-1:0]       disc_a,
  output logic [FLEN-1:0]       disc_b,
  output logic [FLEN-1:0]       disc_c,
  input  logic                  disc_res_vld,
  input  logic [FLEN-1:0]       disc_res,
  input  logic                  disc_res_negative,
  input  logic                  disc_err,
  output logic [N_REQ-1:0]      rsp_vld,
  output logic [FLEN-1:0]       rsp_res,
  output logic                  rsp_negative,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  proto_err
);

  logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d, gnt_idx, head_tag;
  logic [MAX_REQ-1:0] req_ext, gnt_ext;
  logic               unused_gnt;
  logic               fifo_full, fifo_empty, push, pop;
  logic [FLEN-1:0]    sel_a, sel_b, sel_c;
  logic [FLEN-1:0]    disc_a_q, disc_b_q, disc_c_q, rsp_res_q;
  logic               disc_arg_vld_q, rsp_negative_q, rsp_err_q, proto_err_q;
  logic [N_REQ-1:0]   rsp_vld_q, rsp_vld_d;

  // Eligibility looks only at occupancy before any pop, so no disc_* input reaches req_rdy.
  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req_vld & {N_REQ{~fifo_full}};
    gnt_ext              = rr_grant(req_ext, 3'(rr_ptr_q), N_REQ);
  end

  assign req_rdy    = gnt_ext[N_REQ-1:0];
  assign unused_gnt = ^gnt_ext;
  assign push       = |req_rdy;
  assign pop        = disc_res_vld & ~fifo_empty;

  always_comb begin
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_c   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_rdy[i]) begin
        gnt_idx = TAG_W'(i);
        sel_a   = req_a[i*FLEN +: FLEN];
        sel_b   = req_b[i*FLEN +: FLEN];
        sel_c   = req_c[i*FLEN +: FLEN];
      end
    end
  end

  assign rr_ptr_d = (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);

  always_comb begin
    rsp_vld_d = '0;
    if (pop) rsp_vld_d[head_tag] = 1'b1;
  end

  disc_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (gnt_idx),
    .dout  (head_tag),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q       <= '0;
      disc_arg_vld_q <= 1'b0;
      disc_a_q       <= '0;
      disc_b_q       <= '0;
      disc_c_q       <= '0;
      rsp_vld_q      <= '0;
      rsp_res_q      <= '0;
      rsp_negative_q <= 1'b0;
      rsp_err_q      <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      disc_arg_vld_q <= push;
      if (push) begin
        rr_ptr_q <= rr_ptr_d;
        disc_a_q <= sel_a;
        disc_b_q <= sel_b;
        disc_c_q <= sel_c;
      end
      rsp_vld_q <= rsp_vld_d;
      if (disc_res_vld) begin
        rsp_res_q      <= disc_res;
        rsp_negative_q <= disc_res_negative;
        rsp_err_q      <= disc_err;
      end
      if (disc_res_vld && fifo_empty) proto_err_q <= 1'b1;
    end
  end

  assign disc_arg_vld = disc_arg_vld_q;
  assign disc_a       = disc_a_q;
  assign disc_b       = disc_b_q;
  assign disc_c       = disc_c_q;
  assign rsp_vld      = rsp_vld_q;
  assign rsp_res      = rsp_res_q;
  assign rsp_negative = rsp_negative_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = ~fifo_empty | disc_arg_vld_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_float_discriminant_arbiter.sv
// Scoreboard bench: a driver predicts grants from the round-robin rules and queues expected
// responses; an independent monitor pops and compares whenever rsp_vld fires.
module tb_float_discriminant_arbiter;
  import float_discriminant_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_vld = '0;
  logic [N*FLEN-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic [N-1:0]      req_rdy;
  logic              disc_arg_vld;
  logic [FLEN-1:0]   disc_a, disc_b, disc_c;
  logic              disc_res_vld = 1'b0;
  logic [FLEN-1:0]   disc_res = '0;
  logic              disc_res_negative = 1'b0, disc_err = 1'b0;
  logic [N-1:0]      rsp_vld;
  logic [FLEN-1:0]   rsp_res;
  logic              rsp_negative, rsp_err, busy, proto_err;

  float_discriminant_arbiter #(.N_REQ(N), .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .req_rdy(req_rdy), .disc_arg_vld(disc_arg_vld), .disc_a(disc_a), .disc_b(disc_b),
    .disc_c(disc_c), .disc_res_vld(disc_res_vld), .disc_res(disc_res),
    .disc_res_negative(disc_res_negative), .disc_err(disc_err), .rsp_vld(rsp_vld),
    .rsp_res(rsp_res), .rsp_negative(rsp_negative), .rsp_err(rsp_err), .busy(busy),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [63:0] res; logic neg; logic err; int t; } exp_t;
  typedef struct { int due; logic [63:0] res; logic neg; logic err; } unit_t;

  exp_t  sb[$];
  unit_t uq[$];
  unit_t u_item;
  int    lat = 5;
  bit    spur = 1'b0;
  int    nvec = 0, nerr = 0;

  logic [63:0] op_a[N], op_b[N], op_c[N];
  bit          pend[N], refill[N];
  logic [N-1:0] xfer = '0;
  int          m_ptr = 0, m_occ = 0;
  bit          m_argv = 1'b0, m_proto = 1'b0;
  int          glog[$];
  bit          gbits[$];
  logic [N-1:0] last_vld = '0;
  logic [63:0] last_res = '0;
  logic        last_neg = 1'b0;

  function automatic void disc_ref(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                                   output logic [63:0] r, output logic neg, output logic err);
    real ra, rb, rc, d;
    ra  = $bitstoreal(a);
    rb  = $bitstoreal(b);
    rc  = $bitstoreal(c);
    d   = rb * rb - 4.0 * ra * rc;
    r   = $realtobits(d);
    neg = (d < 0.0);
    err = (ra == 0.0);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    nvec++;
    if (got !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic rand_ops(input int i);
    op_a[i] = $realtobits(real'($urandom_range(0, 40)) / 4.0 - 5.0);
    op_b[i] = $realtobits(real'($urandom_range(0, 80)) / 8.0 - 5.0);
    op_c[i] = $realtobits(real'($urandom_range(0, 40)) / 4.0 - 5.0);
  endtask

  // Pipelined discriminant unit stand-in with fixed latency lat.
  always @(negedge clk) begin
    disc_res_vld = 1'b0;
    if (!rst) begin
      uq.delete();
    end else begin
      if (uq.size() > 0 && uq[0].due == cyc) begin
        u_item = uq.pop_front();
        disc_res_vld      = 1'b1;
        disc_res          = u_item.res;
        disc_res_negative = u_item.neg;
        disc_err          = u_item.err;
      end else if (spur) begin
        disc_res_vld = 1'b1;
        disc_res     = {$urandom, $urandom};
        spur         = 1'b0;
      end
      if (disc_arg_vld) begin
        disc_ref(disc_a, disc_b, disc_c, u_item.res, u_item.neg, u_item.err);
        u_item.due = cyc + lat;
        uq.push_back(u_item);
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst && rsp_vld !== '0) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL rsp_unexpected: got rsp_vld %b expected none (cycle %0d)", rsp_vld, cyc);
        end else begin
          e = sb.pop_front();
          $display("rsp: req %0d res %h neg %0b err %0b cycle %0d", e.id, rsp_res, rsp_negative, rsp_err, cyc);
          check("rsp_vld", 64'(rsp_vld), 64'(1) << e.id);
          check("rsp_res", rsp_res, e.res);
          check("rsp_negative", 64'(rsp_negative), 64'(e.neg));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_latency", 64'(cyc), 64'(e.t + 2 + lat));
          last_vld = rsp_vld;
          last_res = rsp_res;
          last_neg = rsp_negative;
        end
      end
    end
  end

  // One clock of stimulus plus grant prediction from the round-robin rules.
  task automatic cycle();
    logic [N-1:0] g;
    logic [63:0]  r;
    logic         n, er, pop;
    int           gid, idx;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (xfer[i]) begin
        pend[i] = refill[i];
        if (refill[i]) rand_ops(i);
      end
    end
    xfer = '0;
    for (int i = 0; i < N; i++) begin
      req_vld[i]           = pend[i];
      req_a[i*FLEN +: FLEN] = op_a[i];
      req_b[i*FLEN +: FLEN] = op_b[i];
      req_c[i*FLEN +: FLEN] = op_c[i];
    end
    #2;
    g   = '0;
    gid = -1;
    if (m_occ < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (gid < 0 && pend[idx]) gid = idx;
      end
    end
    if (gid >= 0) g[gid] = 1'b1;
    check("req_rdy", 64'(req_rdy), 64'(g));
    check("busy", 64'(busy), 64'(m_occ > 0 || m_argv));
    check("disc_arg_vld", 64'(disc_arg_vld), 64'(m_argv));
    check("proto_err", 64'(proto_err), 64'(m_proto));
    pop = disc_res_vld && m_occ > 0;
    if (disc_res_vld && m_occ == 0) m_proto = 1'b1;
    if (gid >= 0) begin
      disc_ref(op_a[gid], op_b[gid], op_c[gid], r, n, er);
      sb.push_back('{gid, r, n, er, cyc});
      glog.push_back(gid);
      m_ptr = (gid + 1) % N;
    end
    xfer   = g;
    m_occ  = m_occ + ((gid >= 0) ? 1 : 0) - (pop ? 1 : 0);
    m_argv = (gid >= 0);
  endtask

  function automatic bit any_pend();
    bit a = 1'b0;
    for (int i = 0; i < N; i++) a |= pend[i];
    return a;
  endfunction

  task automatic drain();
    int b = 0;
    for (int i = 0; i < N; i++) refill[i] = 1'b0;
    while ((any_pend() || m_occ > 0 || m_argv || sb.size() > 0) && b < 600) begin
      cycle();
      b++;
    end
    check("drain_timeout", 64'(b >= 600), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_vld = '0;
    rst     = 1'b0;
    #1;
    check("rst_req_rdy", 64'(req_rdy), 64'(0));
    check("rst_rsp_vld", 64'(rsp_vld), 64'(0));
    check("rst_disc_arg_vld", 64'(disc_arg_vld), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_proto_err", 64'(proto_err), 64'(0));
    for (int i = 0; i < N; i++) begin
      pend[i]   = 1'b0;
      refill[i] = 1'b0;
    end
    xfer    = '0;
    sb.delete();
    m_ptr   = 0;
    m_occ   = 0;
    m_argv  = 1'b0;
    m_proto = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  int cnt;

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      refill[i] = 1'b0;
      op_a[i] = '0;
      op_b[i] = '0;
      op_c[i] = '0;
    end
    #1 rst = 1'b0;
    do_reset();

    // Fairness: all four hold requests for 8 cycles.
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      refill[i] = 1'b1;
      rand_ops(i);
    end
    glog.delete();
    repeat (8) cycle();
    for (int k = 0; k < 8; k++) check("fair_order", 64'(glog[k]), 64'(k % 4));
    drain();

    // Single request from requester 2: 4^2 - 4*1*2 = 8.
    op_a[2] = $realtobits(1.0);
    op_b[2] = $realtobits(4.0);
    op_c[2] = $realtobits(2.0);
    pend[2] = 1'b1;
    drain();
    check("single_vld", 64'(last_vld), 64'(4'b0100));
    check("single_res", last_res, 64'h4020000000000000);
    check("single_neg", 64'(last_neg), 64'(0));

    // Negative result from requester 1: 1 - 4 = -3.
    op_a[1] = $realtobits(1.0);
    op_b[1] = $realtobits(1.0);
    op_c[1] = $realtobits(1.0);
    pend[1] = 1'b1;
    drain();
    check("neg_vld", 64'(last_vld), 64'(4'b0010));
    check("neg_res", last_res, 64'hC008000000000000);
    check("neg_neg", 64'(last_neg), 64'(1));

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          rand_ops(i);
        end
      end
      cycle();
    end
    drain();

    // Full tag FIFO with a 30-cycle unit.
    lat = 30;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      refill[i] = 1'b1;
      rand_ops(i);
    end
    gbits.delete();
    repeat (40) begin
      cycle();
      gbits.push_back(xfer != '0);
    end
    cnt = 0;
    for (int k = 0; k < 16; k++) cnt += int'(gbits[k]);
    check("full_first16", 64'(cnt), 64'(16));
    cnt = 0;
    for (int k = 16; k < 32; k++) cnt += int'(gbits[k]);
    check("full_stall", 64'(cnt), 64'(0));
    check("full_resume", 64'(gbits[32]), 64'(1));
    drain();

    // Spurious result with nothing outstanding.
    lat  = 5;
    spur = 1'b1;
    repeat (6) begin
      cycle();
      check("spur_rsp_vld", 64'(rsp_vld), 64'(0));
    end
    check("spur_proto_err", 64'(proto_err), 64'(1));
    do_reset();

    // Reset with five operations in flight.
    lat = 30;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      refill[i] = 1'b1;
      rand_ops(i);
    end
    glog.delete();
    while (glog.size() < 5) cycle();
    do_reset();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      rand_ops(i);
    end
    glog.delete();
    cycle();
    check("post_reset_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'(0));
    drain();
    repeat (40) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/float_discriminant_arbiter.md
# float_discriminant_arbiter

Shares one fully pipelined `float_discriminant` unit between `N_REQ` independent requesters. The arbiter grants one request per cycle in round-robin order and registers the arguments into the unit. It records the requester ID of every issued operation in an in-order tag FIFO, and steers each result back to the requester that issued it. It sits between the requester clients and the discriminant datapath, replacing per-client copies of the unit.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `FLEN`, 64, float width, taken from the shared package
- `TAG_DEPTH`, 16, tag FIFO depth; must be ≥ unit latency + 2 to sustain one issue per cycle
- `TAG_W`, `$clog2(N_REQ)`, requester ID width (derived)

Ports:
- `clk`  input  1  clock; all logic on rising edge
- `rst`  input  1  reset, asynchronous, active-low
- `req_vld`  input  N_REQ  per-requester request valid
- `req_a`, `req_b`, `req_c`  input  N_REQ*FLEN each  packed per-requester operands; requester i uses slice i
- `req_rdy`  output  N_REQ  one-hot grant; a transfer occurs where `req_vld[i] & req_rdy[i]`
- `disc_arg_vld`  output  1  argument valid to the unit
- `disc_a`, `disc_b`, `disc_c`  output  FLEN  operands to the unit
- `disc_res_vld`  input  1  result valid from the unit
- `disc_res`  input  FLEN  result from the unit
- `disc_res_negative`, `disc_err`  input  1  flags from the unit
- `rsp_vld`  output  N_REQ  one-hot response strobe
- `rsp_res`  output  FLEN  response value, shared by all requesters
- `rsp_negative`, `rsp_err`  output  1  response flags
- `busy`  output  1  operations are in flight
- `proto_err`  output  1  sticky; set when a result arrives with no tag outstanding

## Operation
- Eligibility: `req_vld[i]` is high and the tag FIFO is not full (occupancy < `TAG_DEPTH`).
- Round-robin: pointer `rr_ptr` marks the highest-priority requester. The search runs `rr_ptr`, `rr_ptr+1`, … modulo `N_REQ`. The first eligible requester gets `req_rdy`. After each grant, `rr_ptr` becomes the granted index + 1 (mod `N_REQ`). With no grant, `rr_ptr` holds.
- `req_rdy` is combinational from `req_vld`, `rr_ptr` and FIFO occupancy. It has no combinational path from `disc_*` inputs.
- Requesters hold `req_vld` and operands stable until the transfer. The arbiter does not depend on that for correctness.
- On a grant: the operands are registered into `disc_a/b/c`, `disc_arg_vld` is high the next cycle, and the granted ID is pushed into the tag FIFO in the same cycle as the grant.
- On `disc_res_vld`: the FIFO head is popped. The next cycle, `rsp_vld[head]` goes high and `rsp_res`, `rsp_negative` and `rsp_err` carry the registered unit outputs.
- Push and pop in the same cycle are both legal, including when the FIFO is full: the pop frees space, but the eligibility check uses occupancy before the pop.
- `disc_res_vld` with the FIFO empty: no `rsp_vld`, no pop, `proto_err` set until reset.
- Responses have no backpressure; requesters always accept `rsp_vld`.
- `busy` = FIFO not empty OR `disc_arg_vld`.
- The unit returns results in issue order. The FIFO ordering relies on this.

## Timing
- Request accepted in cycle T.
- `disc_arg_vld` in cycle T+1.
- Result from the unit in T+1+L, where L is the unit latency.
- `rsp_vld` in T+2+L. Total arbiter overhead is 2 cycles.
- Throughput is one grant per cycle while the FIFO is not full.
- Reset (asynchronous assert, synchronous-deassert usage expected):
  - `rr_ptr`=0, FIFO empty
  - `disc_arg_vld`=0, `rsp_vld`=0, `proto_err`=0, `busy`=0
  - data registers are don't-care
- Reset mid-operation: in-flight tags are discarded. Results arriving after reset deassertion with no tag outstanding raise `proto_err`. The system must reset the unit together with the arbiter.

## Structure
- Shared package:
  - `FLEN`
  - `tag_t` (`logic [TAG_W-1:0]`)
  - a round-robin grant function (request vector, pointer → one-hot grant)
- Sub-module `disc_tag_fifo`: synchronous FIFO, width `TAG_W`, depth `TAG_DEPTH`, registered occupancy count, simultaneous push/pop supported.
- The top holds the arbiter, the issue registers and the response registers.

## Test plan
- Single request: requester 2 sends a=1.0, b=4.0, c=2.0 (FLEN=64) → `rsp_vld`=4'b0100 at T+2+L, `rsp_res`=8.0 (0x4020000000000000), `rsp_negative`=0.
- Fairness: all four requesters hold `req_vld` for 8 cycles → grants in order 0,1,2,3,0,1,2,3; each response returns to its issuer.
- Negative result: requester 1 sends a=1.0, b=1.0, c=1.0 → `rsp_res`=-3.0, `rsp_negative`=1, response on `rsp_vld[1]` only.
- Full FIFO: model the unit with L=30 and `TAG_DEPTH`=16, requests every cycle → exactly 16 grants, then `req_rdy`=0 until the first result. In the pop cycle, no grant occurs; grants resume the cycle after.
- Spurious result: drive `disc_res_vld` with the FIFO empty → `rsp_vld` stays 0, `proto_err`=1 until `rst` is asserted low.
- Reset mid-stream: assert `rst` with 5 operations in flight → all outputs are 0 immediately; after release, the next grant goes to requester 0.
